// File: rtl/sd_pkg.sv
// Shared SD command-line definitions: CRC7 polynomial, response frame lengths,
// receiver state encoding and the default NCR timeout.
package sd_pkg;

    localparam logic [6:0] SD_CRC7_POLY   = 7'h09;
    localparam int         SD_RESP_SHORT  = 48;
    localparam int         SD_RESP_LONG   = 136;
    localparam int         SD_NCR_TIMEOUT = 64;
    localparam int         SD_CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RECV = 2'd2
    } sd_rx_state_e;

    // One serial CRC7 step: feedback is the incoming bit xor the remainder MSB.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7_chk.sv
// Serial CRC7 (x^7+x^3+1) with the full remainder exposed for a parallel zero check.
module sd_crc7_chk
    import sd_pkg::*;
(
    input  logic       iclk,
    input  logic       iclr,
    input  logic       ien,
    input  logic       ibit,
    output logic [6:0] ocrc
);

    always_ff @(posedge iclk) begin
        if (iclr) begin
            ocrc <= '0;
        end else if (ien) begin
            ocrc <= crc7_step(ocrc, ibit);
        end
    end

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: start-bit search with NCR timeout, 48/136-bit
// deserialisation, CRC7 and end-bit checking, one-cycle completion pulse.
module sd_resp_rx
    import sd_pkg::*;
#(
    parameter int TIMEOUT = SD_NCR_TIMEOUT
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    input  logic         ilong,
    input  logic         inocrc,
    input  logic         icmd,
    output logic         obusy,
    output logic         odone,
    output logic         otimeout,
    output logic         ocrc_err,
    output logic         oend_err,
    output logic [5:0]   oidx,
    output logic [127:0] oresp
);

    localparam logic [SD_CNT_W-1:0] TO_LAST    = SD_CNT_W'(TIMEOUT - 2);
    localparam logic [SD_CNT_W-1:0] LAST_S     = SD_CNT_W'(SD_RESP_SHORT - 1);
    localparam logic [SD_CNT_W-1:0] LAST_L     = SD_CNT_W'(SD_RESP_LONG - 1);
    localparam logic [SD_CNT_W-1:0] CRC_END_S  = SD_CNT_W'(SD_RESP_SHORT - 2);
    localparam logic [SD_CNT_W-1:0] ARG_END_S  = SD_CNT_W'(SD_RESP_SHORT - 9);
    localparam logic [SD_CNT_W-1:0] DATA_END_L = SD_CNT_W'(SD_RESP_LONG - 2);
    localparam logic [SD_CNT_W-1:0] IDX_BEG    = SD_CNT_W'(2);
    localparam logic [SD_CNT_W-1:0] IDX_END    = SD_CNT_W'(7);
    localparam logic [SD_CNT_W-1:0] DATA_BEG   = SD_CNT_W'(8);

    sd_rx_state_e        state, state_nxt;
    logic [SD_CNT_W-1:0] cnt;
    logic                long_q, nocrc_q;
    logic [5:0]          idx_sh;
    logic [126:0]        data_sh;
    logic [6:0]          crc;

    logic accept, start_det, to_hit, last_bit;
    logic crc_en, data_en, idx_en;

    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (istart)   state_nxt = ST_WAIT;
            ST_WAIT: if (!icmd)    state_nxt = ST_RECV;
                     else if (to_hit) state_nxt = ST_IDLE;
            ST_RECV: if (last_bit) state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // cnt holds the frame position of the bit currently on icmd while in RECV.
    always_comb begin
        accept    = 1'b0;
        start_det = 1'b0;
        to_hit    = 1'b0;
        last_bit  = 1'b0;
        crc_en    = 1'b0;
        data_en   = 1'b0;
        idx_en    = 1'b0;
        case (state)
            ST_IDLE: accept = istart;
            ST_WAIT: begin
                start_det = ~icmd;
                to_hit    = icmd && (cnt == TO_LAST);
            end
            ST_RECV: begin
                last_bit = (cnt == (long_q ? LAST_L : LAST_S));
                idx_en   = (cnt >= IDX_BEG) && (cnt <= IDX_END);
                if (long_q) begin
                    data_en = (cnt >= DATA_BEG) && (cnt <= DATA_END_L);
                    crc_en  = data_en;
                end else begin
                    data_en = (cnt >= DATA_BEG) && (cnt <= ARG_END_S);
                    crc_en  = (cnt <= CRC_END_S);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            cnt     <= '0;
            long_q  <= 1'b0;
            nocrc_q <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            long_q  <= ilong;
            nocrc_q <= inocrc;
        end else if (start_det) begin
            cnt <= SD_CNT_W'(1);
        end else if (state != ST_IDLE) begin
            cnt <= cnt + SD_CNT_W'(1);
        end
    end

    always_ff @(posedge iclk) begin
        if (idx_en) begin
            idx_sh <= {idx_sh[4:0], icmd};
        end
        if (data_en) begin
            data_sh <= {data_sh[125:0], icmd};
        end
    end

    sd_crc7_chk u_crc (
        .iclk (iclk),
        .iclr (irst | accept),
        .ien  (crc_en),
        .ibit (icmd),
        .ocrc (crc)
    );

    // Results are registered on the last bit so they are valid alongside odone.
    always_ff @(posedge iclk) begin
        if (irst) begin
            odone    <= 1'b0;
            otimeout <= 1'b0;
            ocrc_err <= 1'b0;
            oend_err <= 1'b0;
            oidx     <= '0;
            oresp    <= '0;
        end else begin
            odone    <= last_bit;
            otimeout <= to_hit;
            if (accept) begin
                ocrc_err <= 1'b0;
                oend_err <= 1'b0;
                oidx     <= '0;
                oresp    <= '0;
            end else if (last_bit) begin
                oend_err <= ~icmd;
                ocrc_err <= ~nocrc_q & (|crc);
                oidx     <= idx_sh;
                oresp    <= long_q ? {data_sh, 1'b0} : {96'b0, data_sh[31:0]};
            end
        end
    end

    assign obusy = (state != ST_IDLE);

endmodule

// File: tb/tb_sd_resp_rx.sv
// Scoreboard bench for sd_resp_rx: directed and random response frames checked
// against a bit-level reference model using CRC7 polynomial long division.
module tb_sd_resp_rx;

    localparam int TIMEOUT = 64;

    logic         iclk = 1'b0;
    logic         irst, istart, ilong, inocrc, icmd;
    logic         obusy, odone, otimeout, ocrc_err, oend_err;
    logic [5:0]   oidx;
    logic [127:0] oresp;

    sd_resp_rx #(.TIMEOUT(TIMEOUT)) dut (
        .iclk     (iclk),
        .irst     (irst),
        .istart   (istart),
        .ilong    (ilong),
        .inocrc   (inocrc),
        .icmd     (icmd),
        .obusy    (obusy),
        .odone    (odone),
        .otimeout (otimeout),
        .ocrc_err (ocrc_err),
        .oend_err (oend_err),
        .oidx     (oidx),
        .oresp    (oresp)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit           is_to;
        int           at;
        logic [5:0]   idx;
        logic [127:0] resp;
        logic         crc_err;
        logic         end_err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    endtask

    // Remainder of M(x)*x^7 mod (x^7+x^3+1), message bits v[hi] down to v[lo].
    function automatic logic [6:0] crc7_div(input logic [135:0] v, input int hi, input int lo);
        logic [7:0] r;
        logic       b;
        r = 8'h00;
        for (int i = hi; i >= lo - 7; i--) begin
            b = 1'b0;
            if (i >= lo) b = v[i];
            r = {r[6:0], b};
            if (r[7]) r = r ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic exp_t model(input logic [135:0] f, input logic l, input logic nc, input int at);
        exp_t e;
        int   n;
        logic [6:0] calc;
        n         = l ? 136 : 48;
        e.is_to   = 1'b0;
        e.at      = at;
        e.idx     = f[n-3 -: 6];
        e.resp    = l ? {f[127:1], 1'b0} : {96'b0, f[39:8]};
        e.end_err = ~f[0];
        calc      = l ? crc7_div(f, 127, 8) : crc7_div(f, 47, 8);
        e.crc_err = !nc && (calc != f[7:1]);
        return e;
    endfunction

    function automatic logic [135:0] with_crc(input logic [135:0] f, input logic l);
        logic [135:0] g;
        g = f;
        g[7:1] = l ? crc7_div(f, 127, 8) : crc7_div(f, 47, 8);
        return g;
    endfunction

    // Monitor: pops one expectation per completion or timeout pulse.
    always @(negedge iclk) begin
        if (odone === 1'b1 || otimeout === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_event: got odone=%b otimeout=%b at cycle %0d, wanted none",
                         odone, otimeout, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_kind_timeout", otimeout, e.is_to);
                chk("event_cycle", cyc, e.at);
                chk("busy_at_event", obusy, 0);
                if (!e.is_to) begin
                    chk("oidx", oidx, e.idx);
                    chk("oresp", oresp, e.resp);
                    chk("ocrc_err", ocrc_err, e.crc_err);
                    chk("oend_err", oend_err, e.end_err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d events pending", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge iclk);
        #1;
    endtask

    task automatic arm(input logic l, input logic nc);
        istart = 1'b1;
        ilong  = l;
        inocrc = nc;
        icmd   = 1'b1;
        tick();
        istart = 1'b0;
        ilong  = 1'($urandom);
        inocrc = 1'($urandom);
        chk("busy_after_arm", obusy, 1);
    endtask

    // Leaves the caller in the odone cycle of this frame.
    task automatic send(input logic [135:0] f, input logic l, input logic nc,
                        input int gap, input int stray);
        int n;
        n = l ? 136 : 48;
        icmd = 1'b1;
        repeat (gap) tick();
        sb.push_back(model(f, l, nc, cyc + n));
        for (int p = 0; p < n; p++) begin
            icmd = f[n-1-p];
            if (p == stray) begin
                istart = 1'b1;
                ilong  = ~l;
                inocrc = ~nc;
            end else begin
                istart = 1'b0;
            end
            tick();
        end
        istart = 1'b0;
        icmd   = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_odone"}, odone, 0);
        chk({tag, "_otimeout"}, otimeout, 0);
        chk({tag, "_obusy"}, obusy, 0);
        chk({tag, "_ocrc_err"}, ocrc_err, 0);
        chk({tag, "_oend_err"}, oend_err, 0);
        chk({tag, "_oidx"}, oidx, 0);
        chk({tag, "_oresp"}, oresp, 0);
    endtask

    initial begin
        logic [135:0] f, g, cid_frame;
        logic [127:0] cid, rnd;
        int           t, k;
        logic         l, nc;

        irst = 1'b1; istart = 1'b0; ilong = 1'b0; inocrc = 1'b0; icmd = 1'b1;
        repeat (3) tick();
        irst = 1'b0;
        tick();
        chk_all_zero("reset");

        // Directed short frames
        f = {88'b0, 48'h48_000001AA_87};
        arm(0, 0); send(f, 0, 0, 2, -1); tick();
        g = f; g[20] = ~g[20];
        arm(0, 0); send(g, 0, 0, 2, -1); tick();
        arm(0, 1); send(g, 0, 1, 2, -1); tick();
        f = {88'b0, 48'h40_00000000_94};
        arm(0, 0); send(f, 0, 0, 1, -1); tick();

        // Timeout with CMD held high
        t = cyc;
        sb.push_back('{is_to: 1'b1, at: t + TIMEOUT, idx: '0, resp: '0, crc_err: 1'b0, end_err: 1'b0});
        arm(0, 0);
        repeat (TIMEOUT + 3) tick();
        chk("busy_after_timeout", obusy, 0);

        // Long R2 frame, then with a corrupted CRC bit
        cid = 128'h1D41_4453_4430_3030_1000_0001_2300_0C35;
        cid_frame = with_crc({1'b0, 1'b0, 6'h3F, cid[127:1], 1'b1}, 1'b1);
        arm(1, 0); send(cid_frame, 1, 0, 3, -1); tick();
        g = cid_frame; g[3] = ~g[3];
        arm(1, 0); send(g, 1, 0, 0, 40); tick();

        // Reset in the middle of a frame
        f = {88'b0, 48'h48_000001AA_87};
        arm(0, 0);
        icmd = 1'b1; tick(); tick();
        for (int p = 0; p < 20; p++) begin
            icmd = f[47-p];
            tick();
        end
        icmd = f[27];
        irst = 1'b1;
        tick();
        chk_all_zero("midframe_reset");
        irst = 1'b0;
        icmd = 1'b1;
        repeat (3) tick();
        chk("busy_after_reset", obusy, 0);

        // Re-arm in the odone cycle
        arm(0, 0); send(f, 0, 0, 1, -1);
        f = with_crc({88'b0, 1'b0, 1'b0, 6'd17, 32'hDEAD_BEEF, 7'b0, 1'b1}, 1'b0);
        arm(0, 0); send(f, 0, 0, 0, -1); tick();

        // Randomized frames
        for (int it = 0; it < 16; it++) begin
            l   = 1'($urandom);
            nc  = ($urandom_range(0, 3) == 0);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            if (l) f = {1'b0, rnd[127], rnd[5:0], rnd[125:6], 7'b0, 1'b1};
            else   f = {88'b0, 1'b0, rnd[127], rnd[5:0], rnd[63:32], 7'b0, 1'b1};
            f = with_crc(f, l);
            if ($urandom_range(0, 3) == 0) f[0] = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(l ? 134 : 46, 1);
                f[k] = ~f[k];
            end
            arm(l, nc);
            send(f, l, nc, $urandom_range(0, 4),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(2, l ? 133 : 45) : -1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        repeat (5) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sd_resp_rx.md
# sd_resp_rx

Serial receiver for SD-card command-line responses. It sits in the command driver next to the command transmitter. It samples the CMD line once per iclk, detects the start bit, deserialises a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response, and checks the x^7+x^3+1 CRC7 and the end bit. Results are presented to the command FSM with a one-cycle completion pulse.

## Interface
- TIMEOUT, 64: NCR limit, i.e. iclk cycles to wait for a start bit before timing out (≥2).
- iclk  in  1  clock; one CMD bit per cycle (the SD clock domain).
- irst  in  1  reset, synchronous, active-high.
- istart  in  1  arm the receiver (1-cycle pulse); ignored unless idle.
- ilong  in  1  sampled with istart: 1 = 136-bit R2, 0 = 48-bit frame.
- inocrc  in  1  sampled with istart: 1 = skip the CRC check (R3).
- icmd  in  1  CMD line level.
- obusy  out  1  high from the cycle after an accepted istart until done or timeout.
- odone  out  1  1-cycle pulse: frame received; flags and data valid.
- otimeout  out  1  1-cycle pulse: no start bit within TIMEOUT cycles.
- ocrc_err  out  1  valid with odone; held until next accepted istart.
- oend_err  out  1  valid with odone; end bit was 0; held until next accepted istart.
- oidx  out  6  frame bits [45:40] (short), or 6'h3F field (long); held.
- oresp  out  128  short: {96'b0, arg[31:0]}; long: {R2 bits [127:1], 1'b0}; held.

## Operation
- All outputs reset to 0. State resets to IDLE.
- States: IDLE, WAIT, RECV.
- IDLE: on istart, latch ilong/inocrc, clear flags/oidx/oresp, clear the timeout counter and CRC register, then go to WAIT.
- WAIT: if icmd==0, treat it as the start bit, set the bit counter to 1, and go to RECV. Otherwise increment the counter. When the counter reaches TIMEOUT-1 with icmd still 1, pulse otimeout and go to IDLE.
- RECV: shift icmd into the data shift register and increment the bit counter. The counter is 8 bits; the frame length N is 48 or 136.
- CRC feed, short frame: the CRC register (7 bits, zero init, feedback = bit ^ crc[6], taps to crc[0] and crc[3]) receives frame bits 1..39. The start bit is also fed, which is harmless because it is 0 from the zero state. Bits 40..46 are then fed as well. A nonzero remainder means ocrc_err=1, unless inocrc is set.
- CRC feed, long frame: the CRC register covers R2 bits [127:1] only, i.e. frame positions 8..134. It is held at zero during the first 8 bits.
- Last bit (position N-1): oend_err = ~icmd. Go to IDLE; odone pulses on the next cycle with the flags already valid.
- The transmission bit is captured but not checked.
- istart while obusy is ignored. istart in the cycle odone is high is accepted.
- irst at any point returns the block to IDLE and clears all outputs in the next cycle. No odone or otimeout is emitted for the aborted frame.

## Timing
- istart at cycle t: obusy=1 from t+1. icmd is first examined at t+1.
- Start bit sampled at cycle s: last bit sampled at s+N-1. odone=1 and obusy=0 at s+N.
- Timeout: with icmd held at 1 from t+1, otimeout=1 at t+TIMEOUT, and obusy drops in the same cycle.
- Flags and data are stable from odone until the next accepted istart or irst.
- The response path has no combinational path from icmd to any output.

## Structure
- Shared package sd_pkg:
  - CRC7 polynomial constant 7'h09.
  - Frame lengths SD_RESP_SHORT=48 and SD_RESP_LONG=136.
  - State enum for IDLE/WAIT/RECV.
  - Default NCR timeout.
- One natural sub-module: sd_crc7_chk, a serial CRC7 with clear and enable inputs that exposes the full 7-bit remainder. The remainder must be visible in parallel for the zero check, so the serial-out-only CRC generator used on the transmit side is not reused.

## Test plan
- Short, valid: istart with ilong=0, then 2 idle cycles, then frame 48'h48_000001AA_87 MSB first. Required: odone at s+48, oidx=8, oresp=32'h000001AA, ocrc_err=0, oend_err=0.
- CRC error: same frame with bit 20 flipped. Required: ocrc_err=1, oend_err=0. Repeat with inocrc=1. Required: ocrc_err=0.
- End error plus frame 48'h40_00000000_94, i.e. CMD0 with the end bit cleared. Required: oidx=0, ocrc_err=0, oend_err=1.
- Timeout: istart, then icmd=1 forever. Required: otimeout pulse exactly TIMEOUT cycles after istart, no odone, obusy=0 afterwards.
- Long R2: a 136-bit frame built by the golden model with CID 128'h1D41_4453_4430_3030_1000_0001_2300_0C35 (CRC substituted into bits [7:1]). Required: oresp[127:1] equals the frame payload and ocrc_err=0. Then corrupt a CRC bit. Required: ocrc_err=1.
- Reset and re-arm: irst asserted at bit 20 of a frame. Required: obusy=0 and all outputs 0 next cycle, no odone. Then istart during an odone cycle followed by a valid frame. Required: second odone with correct data.
